// File: rtl/k2red_pkg.sv
// Shared latency and width derivations for the streaming K2-RED reducer.
package k2red_pkg;

  // Pipeline depth: capture stage, optional mid register, output stage.
  function automatic int unsigned k2red_lat(input int unsigned ff_mul);
    return (ff_mul != 0) ? 3 : 2;
  endfunction

  // Split point: q = qH * 2^M + 1.
  function automatic int unsigned k2red_m(input int unsigned logq, input int unsigned logqh);
    return logq - logqh;
  endfunction

  // Width of the double-width product C.
  function automatic int unsigned k2red_k(input int unsigned logq);
    return 2 * logq;
  endfunction

  // Signed width of C' = qH*C0 - C1; C1 spans the full K-M upper bits of C.
  function automatic int unsigned k2red_w1(input int unsigned logq, input int unsigned logqh);
    return logq + logqh + 2;
  endfunction

  // Signed width of C'' = qH*C'0 - (C' >>> M), with headroom for the correction adds.
  function automatic int unsigned k2red_w2(input int unsigned logq, input int unsigned logqh);
    int unsigned a;
    a = 2 * logqh + 2;
    return ((logq > a) ? logq : a) + 2;
  endfunction

endpackage

// File: rtl/k2red_lane.sv
// One reduction lane: capture, first K-RED step, second K-RED step with final correction.
module k2red_lane
  import k2red_pkg::*;
#(
  parameter int unsigned LOGQ   = 64,
  parameter int unsigned LOGQH  = 26,
  parameter int unsigned FF_MUL = 1,
  localparam int unsigned LAT   = k2red_lat(FF_MUL)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LAT-1:0]      ld,
  input  logic [LOGQH-1:0]    qh,
  input  logic [2*LOGQ-1:0]   c,
  output logic [LOGQ-1:0]     t
);

  localparam int unsigned M  = k2red_m(LOGQ, LOGQH);
  localparam int unsigned K  = k2red_k(LOGQ);
  localparam int unsigned W1 = k2red_w1(LOGQ, LOGQH);
  localparam int unsigned WC = k2red_w2(LOGQ, LOGQH) + 1;

  logic [K-1:0]            c_s0;
  logic [LOGQH-1:0]        qh_s0;
  logic [W1-1:0]           p1;
  logic signed [W1-1:0]    cp_d;
  logic signed [W1-1:0]    cp_s1;
  logic [LOGQH-1:0]        qh_s1;
  logic signed [WC-1:0]    q1, q2, r0, r1;
  logic [LOGQ-1:0]         t_d;

  // S0: capture the product and the modulus constant of the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_s0  <= '0;
      qh_s0 <= '0;
    end else if (ld[0]) begin
      c_s0  <= c;
      qh_s0 <= qh;
    end
  end

  // First K-RED step: C' = qH*C0 - C1.
  always_comb begin
    p1   = W1'(qh_s0) * W1'(c_s0[M-1:0]);
    cp_d = $signed(p1 - W1'(c_s0[K-1:M]));
  end

  if (FF_MUL != 0) begin : g_ff
    // S1: register the first-step result together with its qH.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cp_s1 <= '0;
        qh_s1 <= '0;
      end else if (ld[1]) begin
        cp_s1 <= cp_d;
        qh_s1 <= qh_s0;
      end
    end
  end else begin : g_comb
    // No mid register: second step follows the first combinationally.
    always_comb begin
      cp_s1 = cp_d;
      qh_s1 = qh_s0;
    end
  end

  // Second K-RED step, then fold into [0, q): one add for negatives, up to 2q off the top.
  always_comb begin
    q1 = $signed(WC'({qh_s1, {M{1'b0}}}) + WC'(1));
    q2 = q1 + q1;
    r0 = $signed(WC'(WC'(qh_s1) * WC'(cp_s1[M-1:0])) - WC'(cp_s1 >>> M));
    r1 = r0[WC-1] ? (r0 + q1) : r0;
    if (r1 >= q2)      t_d = LOGQ'(r1 - q2);
    else if (r1 >= q1) t_d = LOGQ'(r1 - q1);
    else               t_d = LOGQ'(r1);
  end

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            t <= '0;
    else if (ld[LAT-1])    t <= t_d;
  end

endmodule

// File: rtl/k2red_stream.sv
// Multi-lane streaming K2-RED reducer with valid/ready handshake, bubble collapsing and tag sideband.
module k2red_stream
  import k2red_pkg::*;
#(
  parameter int unsigned LOGQ   = 64,
  parameter int unsigned LOGQH  = 26,
  parameter int unsigned LANES  = 4,
  parameter int unsigned FF_MUL = 1,
  parameter int unsigned TAGW   = 8,
  localparam int unsigned LAT   = k2red_lat(FF_MUL),
  localparam int unsigned OCCW  = $clog2(LAT + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LOGQH-1:0]            qH,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*2*LOGQ-1:0]     in_C,
  input  logic [TAGW-1:0]             in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*LOGQ-1:0]       out_T,
  output logic [TAGW-1:0]             out_tag,
  output logic [OCCW-1:0]             occ
);

  localparam int unsigned K = k2red_k(LOGQ);

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
  } ctl_t;

  ctl_t [LAT-1:0] ctl;
  logic [LAT-1:0] en;
  logic [LAT-1:0] ld;
  logic           in_fire;
  logic           out_fire;

  // A stage may load when empty or when its content leaves this cycle; chain runs from out_ready back to in_ready.
  always_comb begin
    en = '0;
    ld = '0;
    en[LAT-1] = !ctl[LAT-1].valid || out_ready;
    for (int unsigned i = LAT - 1; i > 0; i--) en[i-1] = !ctl[i-1].valid || en[i];
    ld[0] = en[0] && in_valid;
    for (int unsigned i = 1; i < LAT; i++) ld[i] = en[i] && ctl[i-1].valid;
  end

  assign in_ready  = en[0];
  assign out_valid = ctl[LAT-1].valid;
  assign out_tag   = ctl[LAT-1].tag;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Stage valid bits and tags advance with the same enables as the lane data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl <= '0;
    end else begin
      if (en[0]) ctl[0].valid <= in_valid;
      if (ld[0]) ctl[0].tag   <= in_tag;
      for (int unsigned i = 1; i < LAT; i++) begin
        if (en[i]) ctl[i].valid <= ctl[i-1].valid;
        if (ld[i]) ctl[i].tag   <= ctl[i-1].tag;
      end
    end
  end

  // Beats in flight: up on input transfer, down on output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     occ <= '0;
    else if (in_fire && !out_fire)  occ <= occ + 1'b1;
    else if (!in_fire && out_fire)  occ <= occ - 1'b1;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    k2red_lane #(
      .LOGQ   (LOGQ),
      .LOGQH  (LOGQH),
      .FF_MUL (FF_MUL)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (ld),
      .qh    (qH),
      .c     (in_C[g*K +: K]),
      .t     (out_T[g*LOGQ +: LOGQ])
    );
  end

endmodule
